// File: rtl/regf_pkg.sv
// Shared register-file writeback definitions: datapath widths and the queued entry layout.
package regf_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regf_wbq_fwd.sv
// One forwarding read port: parallel rd match over age-ordered entries, youngest match wins.
module regf_wbq_fwd
    import regf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t          i_entries [DEPTH],
    input  logic [DEPTH-1:0]   i_valid,
    input  logic [REG_AW-1:0]  i_rs,
    output logic               o_hit_c,
    output logic [XLEN-1:0]    o_data_c
);

    // Index 0 is the oldest entry, so the last match in scan order is the youngest.
    always_comb begin
        o_hit_c  = 1'b0;
        o_data_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i_valid[i] && (i_rs != '0) && (i_entries[i].rd == i_rs)) begin
                o_hit_c  = 1'b1;
                o_data_c = i_entries[i].data;
            end
        end
    end

endmodule

// File: rtl/regf_wb_queue.sv
// Writeback FIFO merging load and ALU results into one register-file write port.
// Define REGF_WBQ_FWD_EN to enable forwarding from pending entries to the two read ports.
module regf_wb_queue
    import regf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              hold,
    output logic              wr,
    output logic [REG_AW-1:0] Ad_rd,
    output logic [XLEN-1:0]   rd_data_in,
    input  logic [REG_AW-1:0] Ad_rs1,
    input  logic [REG_AW-1:0] Ad_rs2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic [XLEN-1:0]   fwd2_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_mem_enq;
    logic             w_alu_enq;
    logic             w_deq;
    logic [CW-1:0]    w_n_enq;
    wb_entry_t        w_head;

    // Readiness uses the registered count only; ALU yields a slot to a pending load.
    assign mem_ready = !rst && (r_count < CW'(DEPTH));
    assign alu_ready = !rst && (mem_valid ? (r_count < CW'(DEPTH - 1)) : (r_count < CW'(DEPTH)));

    // x0 results complete the handshake but never occupy a slot.
    assign w_mem_enq = mem_valid && mem_ready && (mem_rd != '0);
    assign w_alu_enq = alu_valid && alu_ready && (alu_rd != '0);
    assign w_n_enq   = CW'(w_mem_enq) + CW'(w_alu_enq);
    assign w_deq     = (r_count != '0) && !hold;

    assign w_head     = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign wr         = (r_count != '0);
    assign Ad_rd      = w_head.rd;
    assign rd_data_in = w_head.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_n_enq);
            r_rptr  <= r_rptr + PW'(w_deq);
            r_count <= r_count + w_n_enq - CW'(w_deq);
        end
    end

    // Storage carries no reset; the load is older, so it takes the first free slot.
    always_ff @(posedge clk) begin
        if (w_mem_enq) begin
            r_mem[r_wptr] <= '{rd: mem_rd, data: mem_data};
        end
        if (w_alu_enq) begin
            r_mem[r_wptr + PW'(w_mem_enq)] <= '{rd: alu_rd, data: alu_data};
        end
    end

`ifdef REGF_WBQ_FWD_EN
    wb_entry_t        w_age_entries [DEPTH];
    logic [DEPTH-1:0] w_age_valid;

    // Rotate storage into oldest-first order for the youngest-match search.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_age_entries[i] = r_mem[r_rptr + PW'(i)];
            w_age_valid[i]   = (CW'(i) < r_count);
        end
    end

    regf_wbq_fwd #(.DEPTH(DEPTH)) u_fwd1 (
        .i_entries (w_age_entries),
        .i_valid   (w_age_valid),
        .i_rs      (Ad_rs1),
        .o_hit_c   (fwd1_hit),
        .o_data_c  (fwd1_data)
    );

    regf_wbq_fwd #(.DEPTH(DEPTH)) u_fwd2 (
        .i_entries (w_age_entries),
        .i_valid   (w_age_valid),
        .i_rs      (Ad_rs2),
        .o_hit_c   (fwd2_hit),
        .o_data_c  (fwd2_data)
    );
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{Ad_rs1, Ad_rs2};

    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regf_wb_queue.sv
// Directed bench for regf_wb_queue: expected writes go to a scoreboard checked by a monitor.
module tb_regf_wb_queue;
    import regf_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_valid, mem_ready;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              alu_valid, alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              hold;
    logic              wr;
    logic [REG_AW-1:0] Ad_rd;
    logic [XLEN-1:0]   rd_data_in;
    logic [REG_AW-1:0] Ad_rs1, Ad_rs2;
    logic              fwd1_hit, fwd2_hit;
    logic [XLEN-1:0]   fwd1_data, fwd2_data;

    int n_vec = 0;
    int n_err = 0;
    wb_entry_t exp_q[$];

    regf_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .hold(hold), .wr(wr), .Ad_rd(Ad_rd), .rd_data_in(rd_data_in),
        .Ad_rs1(Ad_rs1), .Ad_rs2(Ad_rs2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    endtask

    // A write commits at the next rising edge whenever wr is high, hold low and rst low.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr === 1'b1 && hold === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_rd", 32'(Ad_rd), 32'hFFFF_FFFF);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                chk("write_rd", 32'(Ad_rd), 32'(e.rd));
                chk("write_data", rd_data_in, e.data);
            end
        end
    end

    initial begin
        idle_inputs();
        hold = 1'b0; Ad_rs1 = '0; Ad_rs2 = '0;
        rst = 1'b1;
        // Producer valids must be ignored during reset.
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999;
        #1;
        chk("rst_mem_ready", 32'(mem_ready), 0);
        chk("rst_alu_ready", 32'(alu_ready), 0);
        step(); step();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("post_rst_wr", 32'(wr), 0);
        chk("post_rst_mem_ready", 32'(mem_ready), 1);
        chk("post_rst_alu_ready", 32'(alu_ready), 1);

        // Single transfer
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
        exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        step(); idle_inputs(); #1;
        chk("single_wr", 32'(wr), 1);
        chk("single_rd", 32'(Ad_rd), 5);
        chk("single_data", rd_data_in, 32'hDEADBEEF);
        step();
        chk("single_wr_after", 32'(wr), 0);
        chk("single_rd_empty", 32'(Ad_rd), 0);

        // Dual transfer: mem entry is older
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        exp_q.push_back('{rd: 5'd3, data: 32'h11});
        exp_q.push_back('{rd: 5'd4, data: 32'h22});
        step(); idle_inputs(); #1;
        chk("dual_first_rd", 32'(Ad_rd), 3);
        step();
        chk("dual_second_rd", 32'(Ad_rd), 4);
        step();
        chk("dual_wr_after", 32'(wr), 0);

        // Backpressure with hold
        hold = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hB;
        step(); idle_inputs();
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'hC;
        step(); idle_inputs();
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'hD;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hE;
        #1;
        chk("bp_mem_ready", 32'(mem_ready), 1);
        chk("bp_alu_ready", 32'(alu_ready), 0);
        step();
        chk("bp_full_mem_ready", 32'(mem_ready), 0);
        chk("bp_full_alu_ready", 32'(alu_ready), 0);
        chk("bp_hold_head_rd", 32'(Ad_rd), 1);
        step();
        chk("bp_hold_kept_rd", 32'(Ad_rd), 1);
        chk("bp_hold_kept_wr", 32'(wr), 1);
        idle_inputs();
        exp_q.push_back('{rd: 5'd1, data: 32'hA});
        exp_q.push_back('{rd: 5'd2, data: 32'hB});
        exp_q.push_back('{rd: 5'd6, data: 32'hC});
        exp_q.push_back('{rd: 5'd8, data: 32'hD});
        hold = 1'b0;
        repeat (4) step();
        chk("bp_drained_wr", 32'(wr), 0);

        // Forwarding: youngest match wins
        hold = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1;
        step();
        mem_data = 32'h2;
        step(); idle_inputs();
        Ad_rs1 = 5'd7; Ad_rs2 = 5'd0;
        #1;
`ifdef REGF_WBQ_FWD_EN
        chk("fwd1_hit", 32'(fwd1_hit), 1);
        chk("fwd1_data", fwd1_data, 32'h2);
`else
        chk("fwd1_hit", 32'(fwd1_hit), 0);
        chk("fwd1_data", fwd1_data, 0);
`endif
        chk("fwd2_hit_x0", 32'(fwd2_hit), 0);
        chk("fwd2_data_x0", fwd2_data, 0);
        // Incoming producer data is not searched.
        Ad_rs2 = 5'd5;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h55;
        #1;
        chk("fwd2_no_incoming", 32'(fwd2_hit), 0);
        idle_inputs();
        exp_q.push_back('{rd: 5'd7, data: 32'h1});
        exp_q.push_back('{rd: 5'd7, data: 32'h2});
        hold = 1'b0;
        step(); step();
        chk("fwd_drained_wr", 32'(wr), 0);
        chk("fwd1_hit_empty", 32'(fwd1_hit), 0);

        // x0 discard
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        #1;
        chk("x0_alu_ready", 32'(alu_ready), 1);
        step(); idle_inputs(); #1;
        chk("x0_no_wr", 32'(wr), 0);
        step();
        chk("x0_no_wr_later", 32'(wr), 0);

        // Reset mid-operation discards pending entries
        hold = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0;
        step(); idle_inputs();
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC0;
        step(); idle_inputs();
        chk("mid_wr_pending", 32'(wr), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_ready", 32'(mem_ready), 0);
        chk("mid_rst_alu_ready", 32'(alu_ready), 0);
        step();
        rst = 1'b0;
        hold = 1'b0;
        Ad_rs1 = 5'd10;
        #1;
        chk("mid_post_wr", 32'(wr), 0);
        chk("mid_post_mem_ready", 32'(mem_ready), 1);
        chk("mid_post_alu_ready", 32'(alu_ready), 1);
        chk("mid_post_fwd1", 32'(fwd1_hit), 0);
        repeat (3) step();
        chk("mid_no_stale_wr", 32'(wr), 0);

        chk("scoreboard_leftover", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regf_wb_queue.md
REGF_WB_QUEUE -- requirements
Module: regf_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning writeback FIFO entries (power of two, at least 2).
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have ports: rst  input  1  reset, synchronous, active-high, sampled on rising clk.
REQ-004 SHALL have ports: mem_valid/mem_ready  input/output  1/1  load-result handshake; mem_rd  input  5  destination register; mem_data  input  32  result.
REQ-005 SHALL have ports: alu_valid/alu_ready  input/output  1/1  ALU-result handshake; alu_rd  input  5  destination register; alu_data  input  32  result.
REQ-006 SHALL have ports: hold  input  1  register-file write port unavailable this cycle; head is not drained.
REQ-007 SHALL have ports: wr  output  1  register-file write enable; Ad_rd  output  5  write address; rd_data_in  output  32  write data.
REQ-008 SHALL have ports: Ad_rs1, Ad_rs2  input  5  read addresses; fwd1_hit, fwd2_hit  output  1  a pending entry matches; fwd1_data, fwd2_data  output  32  forwarded value.

Function
REQ-009 SHALL transfer on a port when valid and ready are both high at a rising clk.
REQ-010 SHALL drive mem_ready high iff count < DEPTH, using the registered count with no same-cycle drain credit.
REQ-011 SHALL drive alu_ready high iff count < DEPTH-1 when mem_valid is high, and iff count < DEPTH otherwise.
REQ-012 SHALL enqueue the mem entry ahead of the ALU entry when both transfer in one cycle, because the mem entry is older.
REQ-013 SHALL accept a transfer with rd == 0 and discard it: no enqueue, no slot consumed, no wr.
REQ-014 SHALL drive wr = (count != 0), with Ad_rd and rd_data_in taken combinationally from the head entry; Ad_rd and rd_data_in SHALL be 0 when the FIFO is empty.
REQ-015 SHALL dequeue the head at a rising clk when wr is high and hold is low; with hold high, the head and all outputs SHALL be kept.
REQ-016 SHALL have latency: an entry accepted at edge N, into an empty FIFO with hold low, drives wr during cycle N+1.
REQ-017 SHALL support simultaneous enqueue (0, 1 or 2 entries) and dequeue in one cycle, with count updated by the net change.
REQ-018 SHALL wrap read and write pointers modulo DEPTH; count spans 0..DEPTH; overflow is impossible by REQ-010/011.
REQ-019 SHALL produce, for each read port, a hit for the youngest valid entry whose rd equals Ad_rsX with Ad_rsX != 0; otherwise hit = 0 and data = 0.
REQ-020 SHALL exclude same-cycle incoming producer data from the forwarding search.

Reset
REQ-021 SHALL, while rst is high, force mem_ready = alu_ready = 0 and ignore producer valids.
REQ-022 SHALL clear count and both pointers at a rising clk with rst high, so that wr = 0 and fwd hits = 0 from the next cycle.
REQ-023 SHALL discard all pending entries on reset mid-operation, issuing no further write for them.
REQ-024 SHALL NOT require entry storage to be reset.

Configuration
REQ-025 SHALL, with macro REGF_WBQ_FWD_EN defined, implement REQ-019/020.
REQ-026 SHALL, without REGF_WBQ_FWD_EN, tie fwd1_hit, fwd2_hit, fwd1_data and fwd2_data to 0 and omit the comparators.

Structure
REQ-027 SHALL take XLEN = 32, REG_AW = 5 and the writeback entry typedef (rd, data) from shared package regf_pkg.
REQ-028 SHALL contain one sub-module, regf_wbq_fwd, which holds the parallel match and youngest-first select and is instantiated twice (one per read port) under REGF_WBQ_FWD_EN.

Verification
REQ-029 SHALL test single transfer: mem x5 = 0xDEADBEEF into an empty queue, hold = 0 -> next cycle wr = 1, Ad_rd = 5, rd_data_in = 0xDEADBEEF; the cycle after, wr = 0.
REQ-030 SHALL test dual transfer: mem x3 = 0x11 and alu x4 = 0x22 in the same cycle -> writes x3, then x4, on consecutive cycles.
REQ-031 SHALL test backpressure: hold = 1 with 3 entries queued, then mem_valid and alu_valid both high -> mem accepted, alu_ready = 0; next cycle count = 4 and both readies = 0.
REQ-032 SHALL test forwarding: queue x7 = 0x1, then x7 = 0x2, with hold = 1 and Ad_rs1 = 7 -> fwd1_hit = 1, fwd1_data = 0x2; Ad_rs2 = 0 -> fwd2_hit = 0.
REQ-033 SHALL test x0 discard: alu x0 = 0xFFFF accepted -> count unchanged and no wr pulse.
REQ-034 SHALL test reset mid-operation: rst pulsed for one cycle with 3 entries queued -> wr = 0 afterwards, no stale write, readies high once rst is low.
